cv32e40x_xif_aes_sched: RTL

In-order scheduler between the CV-X-IF issue, commit and result channels and one shared multi-cycle AES32 functional unit. It accepts up to DEPTH outstanding AES32 instructions and tracks commit or kill per X-IF ID. It sequences each instruction into the FU one at a time and returns results in issue order with result-channel backpressure. It sits inside the AES coprocessor, replacing single-entry accept/commit glue so the core can offload back-to-back AES rounds.

---
 rtl/cv32e40x_xif_aes_sched.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40x_xif_aes_sched.sv
// In-order CV-X-IF scheduler feeding one shared multi-cycle AES32 FU.
// Define XIF_AES_SCHED_SPEC_EN to let the head execute before it commits.
module cv32e40x_xif_aes_sched #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  output logic                   issue_accept_o,
  input  logic [31:0]            issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]  issue_id_i,
  input  logic [X_RFR_WIDTH-1:0] issue_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] issue_rs2_i,
  input  logic                   commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]  commit_id_i,
  input  logic                   commit_kill_i,
  output logic                   fu_valid_o,
  output logic [X_RFR_WIDTH-1:0] fu_rs1_o,
  output logic [X_RFR_WIDTH-1:0] fu_rs2_o,
  output logic [1:0]             fu_bs_o,
  output logic [3:0]             fu_op_o,
  input  logic                   fu_ready_i,
  input  logic [X_RFR_WIDTH-1:0] fu_rd_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [X_ID_WIDTH-1:0]  result_id_o,
  output logic [4:0]             result_rd_o,
  output logic [X_RFR_WIDTH-1:0] result_data_o,
  output logic                   busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  localparam logic [6:0] LP_OPC    = 7'b0110011;
  localparam logic [4:0] LP_F5_ES  = 5'b10001;
  localparam logic [4:0] LP_F5_ESM = 5'b10011;
  localparam logic [4:0] LP_F5_DS  = 5'b10101;
  localparam logic [4:0] LP_F5_DSM = 5'b10111;

  localparam logic [1:0] E_EMPTY  = 2'd0;
  localparam logic [1:0] E_PEND   = 2'd1;
  localparam logic [1:0] E_COMMIT = 2'd2;
  localparam logic [1:0] E_KILL   = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]             r_st  [DEPTH];
  logic [X_ID_WIDTH-1:0]  r_id  [DEPTH];
  logic [X_RFR_WIDTH-1:0] r_rs1 [DEPTH];
  logic [X_RFR_WIDTH-1:0] r_rs2 [DEPTH];
  logic [1:0]             r_bs  [DEPTH];
  logic [3:0]             r_op  [DEPTH];
  logic [4:0]             r_rd  [DEPTH];

  logic [AW-1:0]          r_head;
  logic [AW-1:0]          r_tail;
  logic [AW:0]            r_count;
  logic [1:0]             r_fsm;
  logic [X_RFR_WIDTH-1:0] r_res;

  logic [4:0] w_f5;
  logic [3:0] w_op;
  logic       w_hit;
  logic       w_push;
  logic       w_pop;
  logic       w_cap;
  logic [1:0] w_hs;
  logic       w_elig;
  logic [1:0] w_fsm_nxt;
  logic       w_unused;

  assign w_unused = ^issue_instr_i[24:12];
  assign w_f5     = issue_instr_i[29:25];

  always_comb begin
    w_op = 4'b0000;
    if (issue_instr_i[6:0] == LP_OPC) begin
      unique case (1'b1)
        (w_f5 == LP_F5_ES):  w_op = 4'b0001;
        (w_f5 == LP_F5_ESM): w_op = 4'b0010;
        (w_f5 == LP_F5_DS):  w_op = 4'b0100;
        (w_f5 == LP_F5_DSM): w_op = 4'b1000;
        default:             w_op = 4'b0000;
      endcase
    end
  end

  assign w_hit          = |w_op;
  assign issue_ready_o  = (r_count != LP_FULL);
  assign issue_accept_o = issue_valid_i && w_hit && issue_ready_o;
  assign w_push         = issue_accept_o;

  assign w_hs = r_st[r_head];

`ifdef XIF_AES_SCHED_SPEC_EN
  assign w_elig = (w_hs == E_PEND) || (w_hs == E_COMMIT);
`else
  assign w_elig = (w_hs == E_COMMIT);
`endif

  // A late FU pulse seen in IDLE is never captured; only EXEC owns the FU.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_pop     = 1'b0;
    w_cap     = 1'b0;
    unique case (r_fsm)
      S_IDLE: begin
        if (w_hs == E_KILL) begin
          w_pop = 1'b1;
        end else if (w_elig) begin
          w_fsm_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_hs == E_KILL) begin
          w_pop     = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else if (fu_ready_i) begin
          w_cap     = 1'b1;
          w_fsm_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_hs == E_KILL) begin
          w_pop     = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else if (w_hs == E_COMMIT) begin
          if (result_ready_i) begin
            w_pop     = 1'b1;
            w_fsm_nxt = S_IDLE;
          end else begin
            w_fsm_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (result_ready_i) begin
          w_pop     = 1'b1;
          w_fsm_nxt = S_IDLE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  assign fu_valid_o = ((r_fsm == S_IDLE && w_elig) || r_fsm == S_EXEC)
                      && (w_hs != E_KILL);
  assign fu_rs1_o   = r_rs1[r_head];
  assign fu_rs2_o   = r_rs2[r_head];
  assign fu_bs_o    = r_bs[r_head];
  assign fu_op_o    = fu_valid_o ? r_op[r_head] : 4'b0000;

  // HOLD presents the result combinationally so a commit shows next cycle.
  assign result_valid_o = (r_fsm == S_OUT)
                          || (r_fsm == S_HOLD && w_hs == E_COMMIT);
  assign result_id_o    = r_id[r_head];
  assign result_rd_o    = r_rd[r_head];
  assign result_data_o  = r_res;
  assign busy_o         = (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_st[i]  <= E_EMPTY;
        r_id[i]  <= '0;
        r_rs1[i] <= '0;
        r_rs2[i] <= '0;
        r_bs[i]  <= '0;
        r_op[i]  <= '0;
        r_rd[i]  <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_fsm   <= S_IDLE;
      r_res   <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_cap) begin
        r_res <= fu_rd_i;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && r_st[i] == E_PEND
            && r_id[i] == commit_id_i) begin
          r_st[i] <= commit_kill_i ? E_KILL : E_COMMIT;
        end
      end
      if (w_pop) begin
        r_st[r_head] <= E_EMPTY;
        r_head       <= r_head + 1'b1;
      end
      if (w_push) begin
        r_st[r_tail]  <= E_PEND;
        r_id[r_tail]  <= issue_id_i;
        r_rs1[r_tail] <= issue_rs1_i;
        r_rs2[r_tail] <= issue_rs2_i;
        r_bs[r_tail]  <= issue_instr_i[31:30];
        r_op[r_tail]  <= w_op;
        r_rd[r_tail]  <= issue_instr_i[11:7];
        r_tail        <= r_tail + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
